// File: rtl/capture_sequencer.sv
// rtl/capture_sequencer.sv - frame-aligned capture window controller with vsync sync and watchdog
module capture_sequencer #(
    parameter logic [7:0]  FRAMES  = 8'd1,
    parameter logic [26:0] TIMEOUT = 27'd80_000_000,
    parameter logic        VS_POL  = 1'b1
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       sw1,
    input  logic       sw2,
    input  logic       vsync,
    output logic       cap_en,
    output logic       frame_start,
    output logic       frame_done,
    output logic       busy,
    output logic       cont_mode,
    output logic       timeout_err,
    output logic [7:0] frame_cnt
);

    typedef enum logic [1:0] {IDLE, ARM, CAPT} state_t;

    // A zero frame count would otherwise mean "never finish".
    localparam logic [7:0]  FRAMES_EFF = (FRAMES == 8'd0) ? 8'd1 : FRAMES;
    localparam logic [26:0] WD_LAST    = TIMEOUT - 27'd1;

    state_t      state, state_n;
    logic        vs_meta, vs_sync, vs_prev, bnd;
    logic [7:0]  rem, rem_n, cnt_n;
    logic [26:0] wd, wd_n;
    logic        cont_n, terr_n, fs_n, fd_n, cap_n, busy_n;

    // Two-stage synchroniser followed by a registered rising-edge (frame boundary) detector.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            vs_meta <= ~VS_POL;
            vs_sync <= ~VS_POL;
            vs_prev <= ~VS_POL;
            bnd     <= 1'b0;
        end else begin
            vs_meta <= vsync;
            vs_sync <= vs_meta;
            vs_prev <= vs_sync;
            bnd     <= (vs_sync == VS_POL) && (vs_prev != VS_POL);
        end
    end

    // State, counters and all outputs are registered together so they change on the same edge.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state       <= IDLE;
            rem         <= 8'd0;
            wd          <= 27'd0;
            cont_mode   <= 1'b0;
            timeout_err <= 1'b0;
            frame_cnt   <= 8'd0;
            frame_start <= 1'b0;
            frame_done  <= 1'b0;
            cap_en      <= 1'b0;
            busy        <= 1'b0;
        end else begin
            state       <= state_n;
            rem         <= rem_n;
            wd          <= wd_n;
            cont_mode   <= cont_n;
            timeout_err <= terr_n;
            frame_cnt   <= cnt_n;
            frame_start <= fs_n;
            frame_done  <= fd_n;
            cap_en      <= cap_n;
            busy        <= busy_n;
        end
    end

    // Next-state logic: request handling, boundary stepping and watchdog abort.
    always_comb begin
        state_n = state;
        rem_n   = rem;
        wd_n    = wd;
        cont_n  = cont_mode;
        terr_n  = timeout_err;
        cnt_n   = frame_cnt;
        fs_n    = 1'b0;
        fd_n    = 1'b0;
        case (state)
            IDLE: begin
                wd_n = 27'd0;
                if (sw2) begin
                    // sw2 takes priority; a simultaneous sw1 is dropped.
                    cont_n = ~cont_mode;
                    if (!cont_mode) begin
                        state_n = ARM;
                        terr_n  = 1'b0;
                    end
                end else if (sw1) begin
                    state_n = ARM;
                    rem_n   = FRAMES_EFF;
                    terr_n  = 1'b0;
                end
            end
            ARM: begin
                if (sw2) begin
                    cont_n = ~cont_mode;
                end
                if (sw2 && cont_mode) begin
                    state_n = IDLE;
                    wd_n    = 27'd0;
                end else if (bnd) begin
                    state_n = CAPT;
                    fs_n    = 1'b1;
                    wd_n    = 27'd0;
                end else if (wd == WD_LAST) begin
                    state_n = IDLE;
                    cont_n  = 1'b0;
                    terr_n  = 1'b1;
                    wd_n    = 27'd0;
                end else begin
                    wd_n = wd + 27'd1;
                end
            end
            CAPT: begin
                // Leaving continuous mode finishes exactly one more frame.
                if (sw2) begin
                    cont_n = ~cont_mode;
                    rem_n  = 8'd1;
                end
                if (bnd) begin
                    fd_n  = 1'b1;
                    cnt_n = frame_cnt + 8'd1;
                    wd_n  = 27'd0;
                    if (cont_n) begin
                        fs_n = 1'b1;
                    end else if (rem_n <= 8'd1) begin
                        state_n = IDLE;
                    end else begin
                        rem_n = rem_n - 8'd1;
                        fs_n  = 1'b1;
                    end
                end else if (wd == WD_LAST) begin
                    state_n = IDLE;
                    cont_n  = 1'b0;
                    terr_n  = 1'b1;
                    wd_n    = 27'd0;
                end else begin
                    wd_n = wd + 27'd1;
                end
            end
            default: begin
                state_n = IDLE;
            end
        endcase
        cap_n  = (state_n == CAPT);
        busy_n = (state_n != IDLE);
    end

endmodule
